// File: rtl/rv_mem_bridge.sv
// Shared memory bus bridge for the multicycle RV core.
// Arbitrates fetch/data requests onto one valid/ready bus with timeout.
module rv_mem_bridge #(
  parameter int DPWIDTH   = 32,
  parameter int TO_CYCLES = 255,
  parameter int TO_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [DPWIDTH-1:0] i_addr,
  output logic [DPWIDTH-1:0] i_rdata,
  output logic               i_ack,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [DPWIDTH-1:0] d_addr,
  input  logic [DPWIDTH-1:0] d_wdata,
  output logic [DPWIDTH-1:0] d_rdata,
  output logic               d_ack,
  output logic               bus_valid,
  output logic               bus_we,
  output logic [DPWIDTH-1:0] bus_addr,
  output logic [DPWIDTH-1:0] bus_wdata,
  input  logic               bus_ready,
  input  logic               bus_rvalid,
  input  logic [DPWIDTH-1:0] bus_rdata,
  output logic               timeout
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam logic [TO_WIDTH-1:0] TO_MAX = TO_WIDTH'(TO_CYCLES);

  state_t              state;
  logic                own_d;
  logic [TO_WIDTH-1:0] cnt;

  logic               fin;
  logic               cap;
  logic [DPWIDTH-1:0] cap_data;

  // A saturated counter marks the timed-out cycle; late rvalid is ignored.
  always_comb begin
    fin      = 1'b0;
    cap      = 1'b0;
    cap_data = bus_rdata;
    unique case (state)
      REQ: begin
        if (bus_ready) begin
          if (bus_we) begin
            fin = 1'b1;
          end else if (bus_rvalid) begin
            fin = 1'b1;
            cap = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == TO_MAX) begin
          fin      = 1'b1;
          cap      = 1'b1;
          cap_data = '1;
        end else if (bus_rvalid) begin
          fin = 1'b1;
          cap = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      own_d     <= 1'b0;
      cnt       <= '0;
      i_rdata   <= '0;
      i_ack     <= 1'b0;
      d_rdata   <= '0;
      d_ack     <= 1'b0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      timeout   <= 1'b0;
    end else begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req) begin
            own_d     <= 1'b1;
            bus_we    <= d_we;
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
            bus_valid <= 1'b1;
            cnt       <= '0;
            state     <= REQ;
          end else if (i_req) begin
            own_d     <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= i_addr;
            bus_wdata <= '0;
            bus_valid <= 1'b1;
            cnt       <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (!fin) begin
            cnt <= cnt + 1'b1;
            if (cnt == TO_MAX - 1'b1) begin
              timeout <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fin) begin
        state <= DONE;
        if (own_d) d_ack <= 1'b1;
        else       i_ack <= 1'b1;
      end
      if (cap) begin
        if (own_d) d_rdata <= cap_data;
        else       i_rdata <= cap_data;
      end
    end
  end

endmodule

// File: tb/tb_rv_mem_bridge.sv
// Randomized bench for rv_mem_bridge with a transaction-timing reference.
// Two instances: default timeout and a short timeout of 4 cycles.
module tb_rv_mem_bridge;

  localparam int TO_A = 255;
  localparam int TO_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        i_req = 1'b0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        bus_ready = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic a_ireq, a_dreq, b_ireq, b_dreq;
  assign a_ireq = i_req & ~sel;
  assign a_dreq = d_req & ~sel;
  assign b_ireq = i_req & sel;
  assign b_dreq = d_req & sel;

  logic [31:0] a_irdata, a_drdata, a_addr, a_wdata;
  logic        a_iack, a_dack, a_valid, a_we, a_to;
  logic [31:0] b_irdata, b_drdata, b_addr, b_wdata;
  logic        b_iack, b_dack, b_valid, b_we, b_to;

  rv_mem_bridge #(.DPWIDTH(32), .TO_CYCLES(TO_A), .TO_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst),
    .i_req(a_ireq), .i_addr(i_addr),
    .i_rdata(a_irdata), .i_ack(a_iack),
    .d_req(a_dreq), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(a_drdata), .d_ack(a_dack),
    .bus_valid(a_valid), .bus_we(a_we),
    .bus_addr(a_addr), .bus_wdata(a_wdata),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .timeout(a_to)
  );

  rv_mem_bridge #(.DPWIDTH(32), .TO_CYCLES(TO_B), .TO_WIDTH(3)) dut_b (
    .clk(clk), .rst(rst),
    .i_req(b_ireq), .i_addr(i_addr),
    .i_rdata(b_irdata), .i_ack(b_iack),
    .d_req(b_dreq), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(b_drdata), .d_ack(b_dack),
    .bus_valid(b_valid), .bus_we(b_we),
    .bus_addr(b_addr), .bus_wdata(b_wdata),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .timeout(b_to)
  );

  logic [31:0] o_irdata, o_drdata, o_addr, o_wdata;
  logic        o_iack, o_dack, o_valid, o_we, o_to;
  assign o_irdata = sel ? b_irdata : a_irdata;
  assign o_drdata = sel ? b_drdata : a_drdata;
  assign o_addr   = sel ? b_addr   : a_addr;
  assign o_wdata  = sel ? b_wdata  : a_wdata;
  assign o_iack   = sel ? b_iack   : a_iack;
  assign o_dack   = sel ? b_dack   : a_dack;
  assign o_valid  = sel ? b_valid  : a_valid;
  assign o_we     = sel ? b_we     : a_we;
  assign o_to     = sel ? b_to     : a_to;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_ird [2];
  logic [31:0] m_drd [2];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_we"}, 32'(o_we), 32'd0);
    check({tag, "_addr"}, o_addr, 32'd0);
    check({tag, "_wdata"}, o_wdata, 32'd0);
    check({tag, "_irdata"}, o_irdata, 32'd0);
    check({tag, "_drdata"}, o_drdata, 32'd0);
    check({tag, "_iack"}, 32'(o_iack), 32'd0);
    check({tag, "_dack"}, 32'(o_dack), 32'd0);
    check({tag, "_timeout"}, 32'(o_to), 32'd0);
  endtask

  // Entered just after an edge with the selected DUT idle.
  // v<0 means rvalid never comes; v==0 means rvalid together with ready.
  task automatic run_txn(input int s, input bit od, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input int r, input int v);
    int  to_cyc;
    int  ack_at;
    int  to_at;
    bit  tmo;
    bit  hit;
    logic [31:0] exp_rd;
    to_cyc = s ? TO_B : TO_A;
    tmo    = !we && (v < 0 || v > to_cyc);
    if (we || v == 0) ack_at = 2 + r;
    else if (!tmo)    ack_at = 2 + r + v;
    else              ack_at = 3 + r + to_cyc;
    to_at  = tmo ? ack_at - 1 : -1;
    exp_rd = tmo ? 32'hFFFF_FFFF : rd;
    sel = s[0];
    if (od) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = $urandom;
    for (int j = 1; j <= ack_at; j++) begin
      @(posedge clk);
      #1;
      hit = !we && v >= 0 && j == 1 + r + v;
      bus_ready  = (j == 1 + r) || (j == ack_at && $urandom_range(1) == 1);
      bus_rvalid = hit || (j == ack_at && $urandom_range(1) == 1);
      bus_rdata  = hit ? rd : $urandom;
      check("bus_valid", 32'(o_valid), 32'(j <= 1 + r));
      if (j <= 1 + r) begin
        check("bus_we", 32'(o_we), 32'(we));
        check("bus_addr", o_addr, addr);
        if (we) check("bus_wdata", o_wdata, wdata);
      end
      check("timeout", 32'(o_to), 32'(j == to_at));
      check(od ? "d_ack" : "i_ack", 32'(od ? o_dack : o_iack),
            32'(j == ack_at));
      check(od ? "i_ack_idle" : "d_ack_idle",
            32'(od ? o_iack : o_dack), 32'd0);
      if (j == ack_at) begin
        if (!we) begin
          if (od) m_drd[s] = exp_rd;
          else    m_ird[s] = exp_rd;
        end
        check("i_rdata", o_irdata, m_ird[s]);
        check("d_rdata", o_drdata, m_drd[s]);
        if (od) d_req = 1'b0;
        else    i_req = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    check("post_i_ack", 32'(o_iack), 32'd0);
    check("post_d_ack", 32'(o_dack), 32'd0);
  endtask

  initial begin
    int s, r, v;
    bit od, we;
    for (int k = 0; k < 2; k++) begin
      m_ird[k] = '0;
      m_drd[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;

    run_txn(0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0050_0093, 0, 0);
    run_txn(0, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 32'h0, 3, 0);
    i_req  = 1'b1;
    i_addr = 32'h104;
    run_txn(0, 1'b1, 1'b0, 32'h3000, 32'h0, 32'h1234_5678, 1, 2);
    run_txn(0, 1'b0, 1'b0, 32'h104, 32'h0, 32'h0000_0013, 0, 1);
    run_txn(0, 1'b1, 1'b0, 32'h4000, 32'h0, 32'hCAFE_F00D, 0, 10);
    run_txn(1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h5555_AAAA, 0, -1);
    run_txn(1, 1'b1, 1'b0, 32'h208, 32'h0, 32'h0BAD_0BAD, 2, 4);

    for (int k = 0; k < 40; k++) begin
      s  = int'($urandom_range(1));
      od = $urandom_range(1) == 1;
      we = od && $urandom_range(1) == 1;
      r  = int'($urandom_range(3));
      v  = s == 1 ? int'($urandom_range(7)) - 1 : int'($urandom_range(12));
      run_txn(s, od, we, $urandom, $urandom, $urandom, r, v);
    end

    sel = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
    @(posedge clk);
    #1;
    bus_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    d_req = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    check_zero("held_rst");
    for (int k = 0; k < 2; k++) begin
      m_ird[k] = '0;
      m_drd[k] = '0;
    end
    rst = 1'b1;
    run_txn(0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h7777_0001, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
